// File: rtl/otter_io_pkg.sv
// rtl/otter_io_pkg.sv - shared register offsets and bit positions for OTTER IOBUS peripherals
package otter_io_pkg;

    localparam logic [31:0] TMR_BASE_DEFAULT = 32'h1100_D000;

    localparam logic [31:0] TMR_OFS_CTRL   = 32'h0000_0000;
    localparam logic [31:0] TMR_OFS_PRESC  = 32'h0000_0004;
    localparam logic [31:0] TMR_OFS_RELOAD = 32'h0000_0008;
    localparam logic [31:0] TMR_OFS_COUNT  = 32'h0000_000C;
    localparam logic [31:0] TMR_OFS_STATUS = 32'h0000_0010;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;
    localparam int STATUS_EXP    = 0;

    // Full 32-bit match; anything outside the exact word is not ours.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] ofs);
        return addr == (base + ofs);
    endfunction

endpackage

// File: rtl/tmr_prescaler.sv
// rtl/tmr_prescaler.sv - clock divider producing one tick every presc+1 enabled clocks
module tmr_prescaler #(
    parameter int PS_W = 16
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            en,
    input  logic            clr,
    input  logic [PS_W-1:0] presc,
    output logic            tick
);

    logic [PS_W-1:0] pcnt;
    logic            at_top;

    assign at_top = (pcnt == presc);
    // A control write restarts the divider and swallows any tick on that edge.
    assign tick   = en & ~clr & at_top;

    always_ff @(posedge clk) begin
        if (RST || clr || !en) begin
            pcnt <= '0;
        end else if (at_top) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/otter_iobus_timer.sv
// rtl/otter_iobus_timer.sv - memory-mapped countdown timer on the OTTER IOBUS
module otter_iobus_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TMR_BASE_DEFAULT,
    parameter int          PS_W      = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    logic            sel_ctrl, sel_presc, sel_reload, sel_count, sel_status;
    logic            wr_ctrl, wr_presc, wr_reload, wr_count, wr_status;
    logic            ctrl_en, ctrl_periodic, ctrl_ie;
    logic [PS_W-1:0] presc_q;
    logic [31:0]     reload_q;
    logic [31:0]     count_q;
    logic            exp_q;
    logic            tick;
    logic            enable_rise;
    logic            expire;

    assign sel_ctrl   = addr_hit(IOBUS_ADDR, BASE_ADDR, TMR_OFS_CTRL);
    assign sel_presc  = addr_hit(IOBUS_ADDR, BASE_ADDR, TMR_OFS_PRESC);
    assign sel_reload = addr_hit(IOBUS_ADDR, BASE_ADDR, TMR_OFS_RELOAD);
    assign sel_count  = addr_hit(IOBUS_ADDR, BASE_ADDR, TMR_OFS_COUNT);
    assign sel_status = addr_hit(IOBUS_ADDR, BASE_ADDR, TMR_OFS_STATUS);

    assign wr_ctrl   = IOBUS_WR & sel_ctrl;
    assign wr_presc  = IOBUS_WR & sel_presc;
    assign wr_reload = IOBUS_WR & sel_reload;
    assign wr_count  = IOBUS_WR & sel_count;
    assign wr_status = IOBUS_WR & sel_status;

    tmr_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk   (clk),
        .RST   (RST),
        .en    (ctrl_en),
        .clr   (wr_ctrl),
        .presc (presc_q),
        .tick  (tick)
    );

    assign enable_rise = wr_ctrl & IOBUS_OUT[CTRL_EN] & ~ctrl_en;
    // A direct COUNT write on a tick edge takes priority, so expiry is not judged then.
    assign expire      = tick & (count_q == 32'd0) & ~wr_count;

    always_ff @(posedge clk) begin
        if (RST) begin
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_ie       <= 1'b0;
            presc_q       <= '0;
            reload_q      <= '0;
            count_q       <= '0;
            exp_q         <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en       <= IOBUS_OUT[CTRL_EN];
                ctrl_periodic <= IOBUS_OUT[CTRL_PERIODIC];
                ctrl_ie       <= IOBUS_OUT[CTRL_IE];
            end else if (expire && !ctrl_periodic) begin
                ctrl_en <= 1'b0;
            end

            if (wr_presc) begin
                presc_q <= IOBUS_OUT[PS_W-1:0];
            end

            if (wr_reload) begin
                reload_q <= IOBUS_OUT;
            end

            // reload_q is read before any same-edge RELOAD write lands.
            if (wr_count) begin
                count_q <= IOBUS_OUT;
            end else if (enable_rise) begin
                count_q <= reload_q;
            end else if (tick) begin
                if (count_q != 32'd0) begin
                    count_q <= count_q - 32'd1;
                end else if (ctrl_periodic) begin
                    count_q <= reload_q;
                end
            end

            if (expire) begin
                exp_q <= 1'b1;
            end else if (wr_status && IOBUS_OUT[STATUS_EXP]) begin
                exp_q <= 1'b0;
            end
        end
    end

    always_comb begin
        IOBUS_IN = 32'd0;
        if (sel_ctrl) begin
            IOBUS_IN[CTRL_EN]       = ctrl_en;
            IOBUS_IN[CTRL_PERIODIC] = ctrl_periodic;
            IOBUS_IN[CTRL_IE]       = ctrl_ie;
        end else if (sel_presc) begin
            IOBUS_IN = 32'(presc_q);
        end else if (sel_reload) begin
            IOBUS_IN = reload_q;
        end else if (sel_count) begin
            IOBUS_IN = count_q;
        end else if (sel_status) begin
            IOBUS_IN[STATUS_EXP] = exp_q;
        end
    end

    assign INTR = exp_q & ctrl_ie;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// tb/tb_otter_iobus_timer.sv - directed table and sequence bench for otter_iobus_timer
module tb_otter_iobus_timer;

    localparam logic [31:0] BASE = 32'h1100_D000;
    localparam logic [31:0] O_CTRL   = 32'h00;
    localparam logic [31:0] O_PRESC  = 32'h04;
    localparam logic [31:0] O_RELOAD = 32'h08;
    localparam logic [31:0] O_COUNT  = 32'h0C;
    localparam logic [31:0] O_STATUS = 32'h10;

    logic        clk;
    logic        RST;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    int n_chk;
    int n_fail;

    otter_iobus_timer dut (
        .clk        (clk),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [31:0] ofs;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
        IOBUS_ADDR = BASE + ofs;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        @(posedge clk);
        #1;
        IOBUS_WR   = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] ofs, input logic [31:0] exp);
        IOBUS_ADDR = BASE + ofs;
        #1;
        chk(name, IOBUS_IN, exp);
    endtask

    initial begin
        int cycles;
        logic [31:0] ofs_list[5];
        logic [31:0] cnt_exp[6];

        n_chk  = 0;
        n_fail = 0;
        RST        = 1'b1;
        IOBUS_ADDR = 32'd0;
        IOBUS_OUT  = 32'd0;
        IOBUS_WR   = 1'b0;
        ofs_list   = '{O_CTRL, O_PRESC, O_RELOAD, O_COUNT, O_STATUS};

        tbl[0]  = '{1'b1, O_CTRL,        32'hFFFF_FFF8, 32'h0000_0000, "ctrl_hi_bits"};
        tbl[1]  = '{1'b1, O_CTRL,        32'h0000_0006, 32'h0000_0006, "ctrl_per_ie"};
        tbl[2]  = '{1'b1, O_PRESC,       32'hABCD_1234, 32'h0000_1234, "presc_trunc"};
        tbl[3]  = '{1'b1, O_RELOAD,      32'hDEAD_BEEF, 32'hDEAD_BEEF, "reload_rw"};
        tbl[4]  = '{1'b1, O_COUNT,       32'h1234_5678, 32'h1234_5678, "count_rw"};
        tbl[5]  = '{1'b1, O_STATUS,      32'hFFFF_FFFF, 32'h0000_0000, "status_w1c"};
        tbl[6]  = '{1'b1, 32'h14,        32'hFFFF_FFFF, 32'h0000_0000, "hole_0x14"};
        tbl[7]  = '{1'b1, 32'h1000,      32'hFFFF_FFFF, 32'h0000_0000, "hole_0x1000"};
        tbl[8]  = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000, "hole_below"};
        tbl[9]  = '{1'b0, O_CTRL,        32'h0,         32'h0000_0006, "ctrl_kept"};
        tbl[10] = '{1'b0, O_PRESC,       32'h0,         32'h0000_1234, "presc_kept"};
        tbl[11] = '{1'b0, O_RELOAD,      32'h0,         32'hDEAD_BEEF, "reload_kept"};
        tbl[12] = '{1'b0, O_COUNT,       32'h0,         32'h1234_5678, "count_kept"};

        // Reset state
        step();
        step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) chk_rd("reset_read", ofs_list[i], 32'd0);
        chk("reset_intr", 32'(INTR), 32'd0);

        // Register access table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].do_wr) wr(tbl[i].ofs, tbl[i].data);
            chk_rd(tbl[i].name, tbl[i].ofs, tbl[i].exp);
        end
        wr(O_CTRL, 32'd0);
        wr(O_COUNT, 32'd0);

        // One-shot: PRESC=3, RELOAD=4 expires 20 clocks after enable
        wr(O_PRESC, 32'd3);
        wr(O_RELOAD, 32'd4);
        wr(O_CTRL, 32'h5);
        chk("oneshot_intr_early", 32'(INTR), 32'd0);
        cycles = 0;
        while (!INTR && cycles < 100) begin
            step();
            cycles++;
        end
        chk("oneshot_latency", 32'(cycles), 32'd20);
        chk_rd("oneshot_status", O_STATUS, 32'd1);
        chk_rd("oneshot_ctrl", O_CTRL, 32'h4);
        chk_rd("oneshot_count", O_COUNT, 32'd0);
        repeat (5) step();
        chk_rd("oneshot_count_hold", O_COUNT, 32'd0);
        chk("oneshot_intr_hold", 32'(INTR), 32'd1);
        wr(O_STATUS, 32'd1);
        chk("oneshot_intr_clr", 32'(INTR), 32'd0);

        // Periodic: PRESC=0, RELOAD=2, COUNT 2,1,0,2,1,0
        wr(O_PRESC, 32'd0);
        wr(O_RELOAD, 32'd2);
        wr(O_CTRL, 32'h7);
        cnt_exp = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};
        for (int i = 0; i < 6; i++) begin
            chk_rd("periodic_count", O_COUNT, cnt_exp[i]);
            chk("periodic_intr", 32'(INTR), (i >= 3) ? 32'd1 : 32'd0);
            if (i < 5) step();
        end
        // now one edge before the next expiry: clear coincides with it
        wr(O_STATUS, 32'd1);
        chk("clear_vs_expiry", 32'(INTR), 32'd1);
        chk_rd("clear_vs_expiry_cnt", O_COUNT, 32'd2);
        wr(O_STATUS, 32'd1);
        chk("clear_plain", 32'(INTR), 32'd0);
        chk_rd("clear_plain_cnt", O_COUNT, 32'd1);

        // COUNT write on a tick edge wins over the decrement
        wr(O_COUNT, 32'h10);
        chk_rd("count_wr_tick", O_COUNT, 32'h10);
        step();
        chk_rd("count_after_wr", O_COUNT, 32'h0F);
        wr(O_CTRL, 32'd0);
        chk_rd("ctrl_off_tick", O_COUNT, 32'h0F);
        step();
        chk_rd("disabled_hold", O_COUNT, 32'h0F);
        chk_rd("disabled_status", O_STATUS, 32'd0);

        // Reset mid-count
        wr(O_RELOAD, 32'd7);
        wr(O_CTRL, 32'h7);
        chk_rd("rst_pre_count", O_COUNT, 32'd7);
        step();
        step();
        chk_rd("rst_mid_count", O_COUNT, 32'd5);
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) chk_rd("rst_mid_read", ofs_list[i], 32'd0);
        chk("rst_mid_intr", 32'(INTR), 32'd0);
        repeat (20) step();
        chk("rst_no_late_intr", 32'(INTR), 32'd0);
        chk_rd("rst_no_late_status", O_STATUS, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
